// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the data-cache miss controller: line geometry and FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcache_ctrl_pkg;

  // One line is one 64-bit bus beat.
  localparam int LINE_BYTES = 8;
  localparam int OFFSET_W   = 3;

  // One-hot controller states.
  typedef enum logic [10:0] {
    S_IDLE    = 11'b000_0000_0001,
    S_WB_AW   = 11'b000_0000_0010,
    S_WB_B    = 11'b000_0000_0100,
    S_RF_AR   = 11'b000_0000_1000,
    S_RF_R    = 11'b000_0001_0000,
    S_INSTALL = 11'b000_0010_0000,
    S_UC_AR   = 11'b000_0100_0000,
    S_UC_R    = 11'b000_1000_0000,
    S_UC_AW   = 11'b001_0000_0000,
    S_UC_B    = 11'b010_0000_0000,
    S_DONE    = 11'b100_0000_0000
  } state_t;

endpackage

// File: rtl/dcache_merge.sv
// Byte-strobe merge of refill data with the pending store data.
// Latency: purely combinational.
// Backpressure: none.
module dcache_merge #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0]   fill,
  input  logic [DATA_W-1:0]   store_data,
  input  logic [DATA_W/8-1:0] strb,
  input  logic                en,
  output logic [DATA_W-1:0]   line
);

  // Start from the refill beat and overlay each enabled store byte.
  always_comb begin
    line = fill;
    if (en) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (strb[b]) line[b*8 +: 8] = store_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache miss controller: victim write-back, refill, install, and uncached bypass.
// Latency: clean miss holds stall 4 cycles, dirty miss 6, with a zero-wait bus.
// Backpressure: bus valids held with stable payload until ready; pipeline held via stall_req.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 55,
  parameter int INDEX_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_e,
  input  logic                req_we,
  input  logic                req_cache,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic                flush,
  input  logic                tag_miss,
  input  logic                tag_write_back,
  input  logic                tag_lru,
  input  logic [TAG_W-1:0]    victim_tag,
  input  logic [DATA_W-1:0]   victim_data,
  output logic                refresh,
  output logic                data_we,
  output logic                data_way,
  output logic [INDEX_W-1:0]  data_index,
  output logic [DATA_W-1:0]   data_wdata,
  output logic                stall_req,
  output logic [DATA_W-1:0]   uc_rdata,
  output logic                uc_rvalid,
  output logic                bus_ar_valid,
  input  logic                bus_ar_ready,
  output logic [ADDR_W-1:0]   bus_araddr,
  input  logic                bus_r_valid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                bus_aw_valid,
  input  logic                bus_aw_ready,
  output logic [ADDR_W-1:0]   bus_awaddr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_b_valid
);

  state_t              state, state_nx;
  logic                leave_idle;

  // Request snapshot taken when leaving IDLE; everything downstream uses only these.
  logic [ADDR_W-1:0]   cap_addr;
  logic                cap_we;
  logic [DATA_W-1:0]   cap_wdata;
  logic [DATA_W/8-1:0] cap_wstrb;
  logic                cap_lru;
  logic [TAG_W-1:0]    cap_vtag;
  logic [DATA_W-1:0]   cap_vdata;
  logic [DATA_W-1:0]   fill_data;
  logic [DATA_W-1:0]   merged_line;
  logic [DATA_W-1:0]   uc_rdata_q;
  logic                uc_rvalid_q;

  assign leave_idle = (state == S_IDLE) && (state_nx != S_IDLE);
  assign uc_rdata   = uc_rdata_q;
  assign uc_rvalid  = uc_rvalid_q;

  dcache_merge #(.DATA_W(DATA_W)) u_merge (
    .fill       (fill_data),
    .store_data (cap_wdata),
    .strb       (cap_wstrb),
    .en         (cap_we),
    .line       (merged_line)
  );

  // State register; reset abandons any bus handshake in flight.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Request capture on leaving IDLE and refill beat capture in RF_R.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_addr  <= '0;
      cap_we    <= 1'b0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
      cap_lru   <= 1'b0;
      cap_vtag  <= '0;
      cap_vdata <= '0;
      fill_data <= '0;
    end else begin
      if (leave_idle) begin
        cap_addr  <= req_addr;
        cap_we    <= req_we;
        cap_wdata <= req_wdata;
        cap_wstrb <= req_wstrb;
        cap_lru   <= tag_lru;
        cap_vtag  <= victim_tag;
        cap_vdata <= victim_data;
      end
      if (state == S_RF_R && bus_r_valid) fill_data <= bus_rdata;
    end
  end

  // Uncached load result: valid pulses during DONE, data held until the next uncached read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      uc_rdata_q  <= '0;
      uc_rvalid_q <= 1'b0;
    end else begin
      uc_rvalid_q <= (state == S_UC_R) && bus_r_valid;
      if (state == S_UC_R && bus_r_valid) uc_rdata_q <= bus_rdata;
    end
  end

  // Next-state and output decode; flush only matters while IDLE.
  always_comb begin
    state_nx     = state;
    stall_req    = 1'b0;
    refresh      = 1'b0;
    data_we      = 1'b0;
    data_way     = 1'b0;
    data_index   = '0;
    data_wdata   = '0;
    bus_ar_valid = 1'b0;
    bus_araddr   = '0;
    bus_aw_valid = 1'b0;
    bus_awaddr   = '0;
    bus_wdata    = '0;
    bus_wstrb    = '0;
    unique case (state)
      S_IDLE: begin
        if (req_e && !flush) begin
          if (req_cache) begin
            if (tag_miss) begin
              stall_req = 1'b1;
              state_nx  = tag_write_back ? S_WB_AW : S_RF_AR;
            end
          end else begin
            stall_req = 1'b1;
            state_nx  = req_we ? S_UC_AW : S_UC_AR;
          end
        end
      end
      S_WB_AW: begin
        stall_req    = 1'b1;
        bus_aw_valid = 1'b1;
        bus_awaddr   = {cap_vtag, cap_addr[OFFSET_W +: INDEX_W], {OFFSET_W{1'b0}}};
        bus_wdata    = cap_vdata;
        bus_wstrb    = '1;
        if (bus_aw_ready) state_nx = S_WB_B;
      end
      S_WB_B: begin
        stall_req = 1'b1;
        if (bus_b_valid) state_nx = S_RF_AR;
      end
      S_RF_AR: begin
        stall_req    = 1'b1;
        bus_ar_valid = 1'b1;
        bus_araddr   = {cap_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        if (bus_ar_ready) state_nx = S_RF_R;
      end
      S_RF_R: begin
        stall_req = 1'b1;
        if (bus_r_valid) state_nx = S_INSTALL;
      end
      S_INSTALL: begin
        stall_req  = 1'b1;
        refresh    = 1'b1;
        data_we    = 1'b1;
        data_way   = cap_lru;
        data_index = cap_addr[OFFSET_W +: INDEX_W];
        data_wdata = merged_line;
        state_nx   = S_DONE;
      end
      S_UC_AR: begin
        stall_req    = 1'b1;
        bus_ar_valid = 1'b1;
        bus_araddr   = cap_addr;
        if (bus_ar_ready) state_nx = S_UC_R;
      end
      S_UC_R: begin
        stall_req = 1'b1;
        if (bus_r_valid) state_nx = S_DONE;
      end
      S_UC_AW: begin
        stall_req    = 1'b1;
        bus_aw_valid = 1'b1;
        bus_awaddr   = cap_addr;
        bus_wdata    = cap_wdata;
        bus_wstrb    = cap_wstrb;
        if (bus_aw_ready) state_nx = S_UC_B;
      end
      S_UC_B: begin
        stall_req = 1'b1;
        if (bus_b_valid) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule
